test_fifo: RTL and testbench

TEST_FIFO -- requirements
Module: test_fifo

---
 rtl/test_fifo_lane.sv | 82 ++++++++
 rtl/test_fifo.sv | 30 +++
 tb/tb_test_fifo.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/test_fifo_lane.sv
// One self-test lane: a D-deep FIFO fed by a counting pattern generator and
// drained by a checker that expects the same count sequence back.
module test_fifo_lane #(
    parameter int N    = 32,
    parameter int M    = 3,
    parameter int LANE = 0,
    parameter bit INJ  = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic err_o,
    output logic warn_o
);
    localparam int D = 2 ** M;
    localparam logic [N-1:0] START = N'(LANE);

    logic [N-1:0] mem_q [D];
    logic [M-1:0] wr_ptr_q, rd_ptr_q;
    logic [M:0]   count_q, count_d;
    logic         phase_q;
    logic [N-1:0] gen_q, exp_q, rd_data_q;
    logic         rd_valid_q;
    logic         err_q, warn_q;
    logic [2:0]   wr_num_q;

    logic         full, empty, wr_en, rd_en;
    logic [N-1:0] wr_data;

    assign full    = (count_q == (M+1)'(D));
    assign empty   = (count_q == '0);
    assign wr_en   = !full && !rst_i;
    assign rd_en   = phase_q && !empty && !rst_i;
    // Fault injection flips bit 0 of the 6th accepted write only; the counter keeps counting.
    assign wr_data = gen_q ^ {{(N-1){1'b0}}, (INJ && (wr_num_q == 3'd5))};

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (M+1)'(1);
            2'b01:   count_d = count_q - (M+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
        if (rd_en) rd_data_q <= mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            phase_q    <= 1'b0;
            gen_q      <= START;
            exp_q      <= START;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            warn_q     <= 1'b0;
            wr_num_q   <= '0;
        end else begin
            count_q    <= count_d;
            phase_q    <= !phase_q;
            rd_valid_q <= rd_en;
            warn_q     <= (count_q >= (M+1)'(D - 1));
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + M'(1);
                gen_q    <= gen_q + N'(1);
                if (wr_num_q != 3'd6) wr_num_q <= wr_num_q + 3'd1;
            end
            if (rd_en) rd_ptr_q <= rd_ptr_q + M'(1);
            if (rd_valid_q) begin
                exp_q <= exp_q + N'(1);
                if (rd_data_q != exp_q) err_q <= 1'b1;
            end
        end
    end

    assign err_o  = err_q;
    assign warn_o = warn_q;
endmodule

// File: rtl/test_fifo.sv
// K independent FIFO self-test lanes; each reports a sticky data error and a
// near-full warning.
module test_fifo #(
    parameter int N        = 32,
    parameter int M        = 3,
    parameter int K        = 192,
    parameter int INJ_LANE = -1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    output logic [K-1:0] fifo_err_o,
    output logic [K-1:0] pg_warn_o
);
    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_lane
            test_fifo_lane #(
                .N    (N),
                .M    (M),
                .LANE (gi),
                .INJ  (INJ_LANE == gi)
            ) u_lane (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .err_o  (fifo_err_o[gi]),
                .warn_o (pg_warn_o[gi])
            );
        end
    endgenerate
endmodule

// File: tb/tb_test_fifo.sv
// Drives three test_fifo configurations through randomized reset/run phases and
// compares them each cycle against a queue-based model of the lane behaviour.
module tb_test_fifo;
    localparam int D  = 8;
    localparam int NM = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [191:0] err_a, warn_a, err_b, warn_b;
    logic [3:0]   err_c, warn_c;

    always #5 clk = ~clk;

    test_fifo #(.N(32), .M(3), .K(192), .INJ_LANE(-1)) dut_a (
        .clk_i(clk), .rst_i(rst), .fifo_err_o(err_a), .pg_warn_o(warn_a));
    test_fifo #(.N(32), .M(3), .K(192), .INJ_LANE(5)) dut_b (
        .clk_i(clk), .rst_i(rst), .fifo_err_o(err_b), .pg_warn_o(warn_b));
    test_fifo #(.N(8), .M(3), .K(4), .INJ_LANE(-1)) dut_c (
        .clk_i(clk), .rst_i(rst), .fifo_err_o(err_c), .pg_warn_o(warn_c));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: occupancy is identical in every lane, so one queue of write
    // ordinals per configuration; lane data is derived as (lane + ordinal).
    int           mk   [NM] = '{192, 192, 4};
    int           mn   [NM] = '{32, 32, 8};
    int           minj [NM] = '{-1, 5, -1};
    int           mq   [NM][$];
    bit           mphase [NM];
    int           mwr [NM], mrd [NM], mpidx [NM], mpord [NM];
    bit           mval [NM];
    bit           mwarn [NM];
    logic [191:0] merr [NM];

    function automatic longint mask_of(input int di);
        return (64'd1 << mn[di]) - 64'd1;
    endfunction

    function automatic longint lane_word(input int di, input int k, input int idx);
        longint v;
        v = (longint'(k) + longint'(idx)) & mask_of(di);
        if (k == minj[di] && idx == 5) v = v ^ 64'd1;
        return v;
    endfunction

    task automatic model_step();
        for (int di = 0; di < NM; di++) begin
            if (rst) begin
                mq[di].delete();
                mphase[di] = 0; mwr[di] = 0; mrd[di] = 0;
                mval[di] = 0; mwarn[di] = 0; merr[di] = '0;
            end else begin
                int sz;
                bit rd, wr;
                sz = mq[di].size();
                if (mval[di])
                    for (int k = 0; k < mk[di]; k++)
                        if (lane_word(di, k, mpidx[di]) != ((longint'(k) + longint'(mpord[di])) & mask_of(di)))
                            merr[di][k] = 1'b1;
                mwarn[di] = (sz >= D - 1);
                rd = mphase[di] && (sz > 0);
                wr = (sz < D);
                mval[di] = rd;
                if (rd) begin
                    mpidx[di] = mq[di].pop_front();
                    mpord[di] = mrd[di];
                    mrd[di]++;
                end
                if (wr) begin
                    mq[di].push_back(mwr[di]);
                    mwr[di]++;
                end
                mphase[di] = !mphase[di];
            end
        end
    endtask

    task automatic tick();
        logic [191:0] wexp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("err_a", err_a, merr[0]);
        chk("err_b", err_b, merr[1]);
        chk("err_c", err_c, merr[2][3:0]);
        wexp = mwarn[0] ? '1 : '0;
        chk("warn_a", warn_a, wexp);
        wexp = mwarn[1] ? '1 : '0;
        chk("warn_b", warn_b, wexp);
        wexp = mwarn[2] ? '1 : '0;
        chk("warn_c", warn_c, wexp[3:0]);
        chk("rdv_a0", dut_a.g_lane[0].u_lane.rd_valid_q, mval[0]);
        chk("rdv_a191", dut_a.g_lane[191].u_lane.rd_valid_q, mval[0]);
        chk("rdv_c3", dut_c.g_lane[3].u_lane.rd_valid_q, mval[2]);
        if (mval[0]) begin
            chk("rd_a0", dut_a.g_lane[0].u_lane.rd_data_q, longint'(mpord[0]) & mask_of(0));
            chk("rd_a191", dut_a.g_lane[191].u_lane.rd_data_q, (longint'(mpord[0]) + 191) & mask_of(0));
        end
        if (mval[2])
            chk("rd_c3", dut_c.g_lane[3].u_lane.rd_data_q, (longint'(mpord[2]) + 3) & mask_of(2));
    endtask

    task automatic run_phase(input int rst_len, input int run_len);
        logic [191:0] one5;
        one5 = 192'd1 << 5;
        rst = 1'b1;
        for (int i = 0; i < rst_len; i++) tick();
        rst = 1'b0;
        for (int i = 1; i <= run_len; i++) begin
            tick();
            if (i == 1) begin
                chk("rel_err_b", err_b, '0);
                chk("rel_warn_a", warn_a, '0);
            end
            if (i == 16) chk("warn_by16", warn_a, {192{1'b1}});
            if (i == 20) chk("inj_only5", err_b, one5);
        end
        $display("phase: reset %0d cycles, run %0d cycles, lane0 reads %0d, lane3(N=8) reads %0d",
                 rst_len, run_len, mrd[0], mrd[2]);
    endtask

    initial begin
        rst = 1'b1;
        run_phase(10, 50);
        run_phase(3, 30);
        for (int p = 0; p < 3; p++)
            run_phase(int'($urandom_range(1, 4)), int'($urandom_range(5, 40)));
        run_phase(2, 600);
        chk("wrap_seen", (mrd[2] + 3 > 256), 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
